// File: rtl/slave_pkg.sv
// slave_pkg: declarations shared by slave_port and its register bank.
//   - ADDR_W / DATA_W / NUM_REGS : geometry of the 8 x 3-bit bank
//   - CNT_W / TXN_MAX            : width and ceiling of the transaction counter
//   - LAT_W                      : width of the service-latency down-counter
//   - state_t                    : write-acceptance FSM states
package slave_pkg;

  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 3;
  localparam int NUM_REGS = 8;
  localparam int CNT_W    = 8;
  localparam int LAT_W    = 4;

  localparam logic [CNT_W-1:0] TXN_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2,
    ACK   = 2'd3
  } state_t;

endpackage

// File: rtl/slave_regfile.sv
// slave_regfile: 8 x 3-bit register bank with one synchronous write port and
// one registered read port. A read of the entry being written on the same
// edge returns the incoming data.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (clears bank and read data)
//   i_we              write enable
//   i_waddr, i_wdata  write index and data
//   i_raddr           read index, sampled every edge
//   o_rdata           registered read data
module slave_regfile
  import slave_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_bank [NUM_REGS];
  logic [DATA_W-1:0] r_rdata;
  logic              w_bypass;

  assign w_bypass = i_we && (i_waddr == i_raddr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_bank[i] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) begin
        r_bank[i_waddr] <= i_wdata;
      end
      // Write-through: the bank update lands on this same edge, so the read
      // must take the incoming data rather than the stale entry.
      if (w_bypass) begin
        r_rdata <= i_wdata;
      end else begin
        r_rdata <= r_bank[i_raddr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/slave_port.sv
// slave_port: write-target slave downstream of the two-master interconnect.
// Waits LATENCY cycles after first seeing a request, pulses ready_out for one
// cycle, writes the bank on the transfer edge, then expects the interconnect's
// confirmation pulse in the following (ACK) cycle.
// Parameter:
//   LATENCY       extra wait cycles before accepting a request (0..15)
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   valid_in      write request, held until the transfer edge
//   addr_in       target register index
//   value_in      write data
//   handshake_in  transfer confirmation, expected only in the ACK cycle
//   err_clr       synchronous clear of err_out (wins over a same-cycle error)
//   rd_addr       read index
//   ready_out     one-cycle accept pulse (registered)
//   rd_data       registered read data with same-edge write bypass
//   wr_done       one-cycle pulse after a confirmed write
//   txn_count     confirmed writes, saturating at 255
//   err_out       sticky protocol-error flag
module slave_port
  import slave_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] value_in,
  input  logic              handshake_in,
  input  logic              err_clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              ready_out,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_done,
  output logic [CNT_W-1:0]  txn_count,
  output logic              err_out
);

  // Counter preload; the LATENCY=0 value is never used because IDLE bypasses WAIT.
  localparam logic [LAT_W-1:0] LAT_M1 = (LATENCY == 0) ? '0 : LAT_W'(LATENCY - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == TXN_MAX) ? v : v + 1'b1;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LAT_W-1:0]   r_cnt;
  logic [LAT_W-1:0]   w_cnt_nxt;
  logic               r_ready;
  logic               r_wr_done;
  logic [CNT_W-1:0]   r_txn;
  logic               r_err;
  logic               w_err_set;
  logic               w_we;
  logic               w_confirm;

  // The write happens on the edge that ends READY, provided the request is still held.
  assign w_we      = (r_state == READY) && valid_in;
  assign w_confirm = (r_state == ACK) && handshake_in;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (valid_in) begin
          if (LATENCY == 0) begin
            w_state_nxt = READY;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (!valid_in) begin
          w_state_nxt = IDLE;
          w_err_set   = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nxt = READY;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      READY: begin
        if (valid_in) begin
          w_state_nxt = ACK;
        end else begin
          w_state_nxt = IDLE;
          w_err_set   = 1'b1;
        end
      end
      ACK: begin
        // A request held through ACK is re-sampled from IDLE next cycle.
        w_state_nxt = IDLE;
        if (!handshake_in) begin
          w_err_set = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // A confirmation outside the ACK cycle is a protocol violation.
    if (handshake_in && (r_state != ACK)) begin
      w_err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_wr_done <= 1'b0;
      r_txn     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      // Registered copy of "in READY" so ready_out comes straight from a flop.
      r_ready   <= (w_state_nxt == READY);
      r_wr_done <= w_confirm;
      if (w_confirm) begin
        r_txn <= sat_inc(r_txn);
      end
      if (err_clr) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  slave_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (addr_in),
    .i_wdata (value_in),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  assign ready_out = r_ready;
  assign wr_done   = r_wr_done;
  assign txn_count = r_txn;
  assign err_out   = r_err;

endmodule

// File: tb/tb_slave_port.sv
// tb_slave_port: scoreboard bench for slave_port. Two instances are driven
// independently: index 0 with LATENCY=0, index 1 with LATENCY=2. Stimulus
// pushes the expected ready_out cycle and post-write txn_count into queues;
// a negedge monitor pops them whenever the DUT pulses ready_out / wr_done.
// A behavioural model (bank array, counter, error flag) supplies all other
// expected values.
module tb_slave_port;

  logic       clk;
  logic       rst_n;
  logic       vi  [2];
  logic [2:0] ai  [2];
  logic [2:0] di  [2];
  logic       hi  [2];
  logic       ci  [2];
  logic [2:0] ra  [2];
  logic       rdy [2];
  logic [2:0] rdd [2];
  logic       wd  [2];
  logic [7:0] tc  [2];
  logic       er  [2];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  int mbank [2][8];
  int mcnt  [2];
  int merr  [2];

  int rq0[$];
  int rq1[$];
  int wq0[$];
  int wq1[$];

  slave_port #(.LATENCY(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .valid_in(vi[0]), .addr_in(ai[0]), .value_in(di[0]),
    .handshake_in(hi[0]), .err_clr(ci[0]), .rd_addr(ra[0]), .ready_out(rdy[0]),
    .rd_data(rdd[0]), .wr_done(wd[0]), .txn_count(tc[0]), .err_out(er[0])
  );

  slave_port #(.LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .valid_in(vi[1]), .addr_in(ai[1]), .value_in(di[1]),
    .handshake_in(hi[1]), .err_clr(ci[1]), .rd_addr(ra[1]), .ready_out(rdy[1]),
    .rd_data(rdd[1]), .wr_done(wd[1]), .txn_count(tc[1]), .err_out(er[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic push_r(input int d, input int v);
    if (d == 0) rq0.push_back(v); else rq1.push_back(v);
  endtask

  task automatic push_w(input int d, input int v);
    if (d == 0) wq0.push_back(v); else wq1.push_back(v);
  endtask

  // Monitor: every ready_out / wr_done pulse must match a queued expectation.
  task automatic mon(input int d);
    int e;
    bit have;
    if (rdy[d]) begin
      have = 1'b0;
      if (d == 0 && rq0.size() > 0) begin e = rq0.pop_front(); have = 1'b1; end
      else if (d == 1 && rq1.size() > 0) begin e = rq1.pop_front(); have = 1'b1; end
      if (have) chk($sformatf("ready_cycle_d%0d", d), cyc, e);
      else chk($sformatf("ready_unexpected_d%0d", d), 1, 0);
    end
    if (wd[d]) begin
      have = 1'b0;
      if (d == 0 && wq0.size() > 0) begin e = wq0.pop_front(); have = 1'b1; end
      else if (d == 1 && wq1.size() > 0) begin e = wq1.pop_front(); have = 1'b1; end
      if (have) chk($sformatf("txn_at_wr_done_d%0d", d), int'(tc[d]), e);
      else chk($sformatf("wr_done_unexpected_d%0d", d), 1, 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) mbank[d][i] = 0;
      mcnt[d] = 0;
      merr[d] = 0;
    end
  endtask

  task automatic chk_outs_zero(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_d%0d", nm, d),
          int'({rdy[d], rdd[d], wd[d], tc[d], er[d]}), 0);
    end
  endtask

  // All tasks below start and end at posedge+1.
  task automatic do_write(input int d, input int a, input int v, input bit hs, input bit byp);
    bit seen;
    ai[d] = 3'(a);
    di[d] = 3'(v);
    vi[d] = 1'b1;
    if (byp) ra[d] = 3'(a);
    push_r(d, cyc + 1 + lat_of(d));
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (rdy[d]) seen = 1'b1;
    end
    if (!seen) begin
      chk($sformatf("ready_timeout_d%0d", d), 0, 1);
      vi[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;              // transfer edge done, now in ACK
    vi[d] = 1'b0;
    hi[d] = hs;
    mbank[d][a] = v;
    if (byp) chk($sformatf("bypass_d%0d", d), int'(rdd[d]), v);
    if (hs) begin
      mcnt[d] = (mcnt[d] < 255) ? mcnt[d] + 1 : 255;
    end else begin
      merr[d] = 1;
    end
    @(posedge clk); #1;              // ACK done; wr_done visible now
    hi[d] = 1'b0;
    if (hs) push_w(d, mcnt[d]);
  endtask

  task automatic rd_check(input int d, input int a);
    ra[d] = 3'(a);
    @(posedge clk); #1;
    chk($sformatf("rd_d%0d_a%0d", d, a), int'(rdd[d]), mbank[d][a]);
  endtask

  task automatic clr_err(input int d, input bit stray_hs);
    ci[d] = 1'b1;
    hi[d] = stray_hs;
    @(posedge clk); #1;
    ci[d] = 1'b0;
    hi[d] = 1'b0;
    merr[d] = 0;
    chk($sformatf("err_after_clr_d%0d", d), int'(er[d]), merr[d]);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int a, v;
    bit hs, byp, seen;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vi[d] = 1'b0; ai[d] = '0; di[d] = '0; hi[d] = 1'b0; ci[d] = 1'b0; ra[d] = '0;
    end
    model_reset();
    #2;
    chk_outs_zero("reset_state");
    release_reset();

    // Basic write, LATENCY=2
    do_write(1, 5, 3, 1'b1, 1'b0);
    chk("basic_txn", int'(tc[1]), 1);
    rd_check(1, 5);

    // LATENCY=0 back-to-back writes to the same address
    do_write(0, 1, 6, 1'b1, 1'b0);
    do_write(0, 1, 2, 1'b1, 1'b0);
    rd_check(0, 1);
    chk("b2b_txn", int'(tc[0]), 2);
    chk("b2b_err", int'(er[0]), 0);

    // Missing handshake: error is sticky, write is kept
    do_write(1, 4, 6, 1'b0, 1'b0);
    chk("nohs_err", int'(er[1]), merr[1]);
    repeat (3) @(posedge clk);
    #1;
    chk("nohs_err_sticky", int'(er[1]), 1);
    rd_check(1, 4);
    chk("nohs_txn", int'(tc[1]), mcnt[1]);
    clr_err(1, 1'b0);

    // Withdrawal in WAIT
    ai[1] = 3'd6; di[1] = 3'd5; vi[1] = 1'b1;
    @(posedge clk); #1;              // E0: now in WAIT
    vi[1] = 1'b0;
    @(posedge clk); #1;
    merr[1] = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("withdraw_err", int'(er[1]), merr[1]);
    rd_check(1, 6);
    clr_err(1, 1'b0);

    // Stray handshake in IDLE, then clear racing a stray handshake
    hi[1] = 1'b1;
    @(posedge clk); #1;
    hi[1] = 1'b0;
    merr[1] = 1;
    chk("stray_hs_err", int'(er[1]), merr[1]);
    clr_err(1, 1'b1);

    // Bypass: read address tracks write address on the transfer edge
    do_write(1, 2, 7, 1'b1, 1'b1);

    // Random traffic on the LATENCY=2 instance
    for (int n = 0; n < 20; n++) begin
      a   = int'($urandom_range(0, 7));
      v   = int'($urandom_range(0, 7));
      hs  = ($urandom_range(0, 3) != 0);
      byp = 1'($urandom_range(0, 1));
      do_write(1, a, v, hs, byp);
    end
    chk("rand_err", int'(er[1]), merr[1]);
    chk("rand_txn", int'(tc[1]), mcnt[1]);
    for (int i = 0; i < 8; i++) rd_check(1, i);
    clr_err(1, 1'b0);

    // Saturation on the LATENCY=0 instance
    for (int n = 0; n < 260; n++) begin
      do_write(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b1, 1'b0);
    end
    chk("sat_txn", int'(tc[0]), 255);
    for (int i = 0; i < 8; i++) rd_check(0, i);
    ra[0] = 3'd1;

    // Async reset mid-WAIT
    ra[1] = 3'd5;
    ai[1] = 3'd5; di[1] = 3'd1; vi[1] = 1'b1;
    @(posedge clk); #1;              // WAIT, cnt=1
    @(posedge clk); #2;              // WAIT, cnt=0
    rst_n = 1'b0;
    #1;
    chk_outs_zero("rst_wait");
    vi[1] = 1'b0;
    model_reset();
    release_reset();
    rd_check(1, 5);
    rd_check(0, 1);

    // Async reset in READY
    ai[1] = 3'd3; di[1] = 3'd4; vi[1] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (rdy[1]) seen = 1'b1;
    end
    chk("ready_seen_before_rst", int'(seen), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_outs_zero("rst_ready");
    vi[1] = 1'b0;
    model_reset();
    release_reset();
    rd_check(1, 3);

    // Fresh transaction after reset behaves like the basic write
    do_write(1, 5, 3, 1'b1, 1'b0);
    chk("post_rst_txn", int'(tc[1]), 1);
    rd_check(1, 5);
    chk("post_rst_err", int'(er[1]), 0);

    repeat (2) @(posedge clk);
    #1;
    chk("ready_expect_left", rq0.size() + rq1.size(), 0);
    chk("wrdone_expect_left", wq0.size() + wq1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
